// File: rtl/alu_pkg.sv
// Shared control encoding for the pipelined ALU: decode control word and mul-select codes.
package alu_pkg;

   typedef struct packed {
      logic       pre_x_en;
      logic       pre_x_sub;
      logic       pre_y_en;
      logic       pre_y_sub;
      logic [2:0] mul_x_sel;
      logic [2:0] mul_y_sel;
      logic       post_en;
      logic       post_sub;
      logic       acc_en;
      logic       acc_clr;
   } alu_ctrl_t;

   // Post-add controls carried down the pipe alongside the lane data.
   typedef struct packed {
      logic post_en;
      logic post_sub;
      logic acc_en;
      logic acc_clr;
   } post_ctrl_t;

   localparam logic [2:0] MUL_SEL_IN0 = 3'd0;
   localparam logic [2:0] MUL_SEL_IN1 = 3'd1;
   localparam logic [2:0] MUL_SEL_PRE = 3'd2;
   localparam logic [2:0] MUL_SEL_OTH = 3'd3;
   localparam logic [2:0] MUL_SEL_ONE = 3'd4;

endpackage

// File: rtl/alu_lane.sv
// One ALU lane: S1 pre-add and multiplier operand select, S2 multiply (or operand concat).
module alu_lane
   import alu_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            s1_ld_i,
   input  logic            s2_ld_i,
   input  logic [W-1:0]    in0_i,
   input  logic [W-1:0]    in1_i,
   input  logic [W-1:0]    oth_in1_i,
   input  logic            en_i,
   input  logic            sub_i,
   input  logic [2:0]      sel_i,
   output logic [2*W+1:0]  prod_o
);

   localparam int unsigned PW = 2 * W + 2;

   logic [W:0]    pre_d, pre_q;
   logic [W:0]    m1_d, m1_q;
   logic          en_q;
   logic [PW-1:0] prod_d, prod_q;
   logic [PW-1:0] a_ext, b_ext;

   always_comb begin
      pre_d = {1'b0, in0_i};
      if (en_i) begin
         pre_d = sub_i ? ({1'b0, in0_i} - {1'b0, in1_i}) : ({1'b0, in0_i} + {1'b0, in1_i});
      end
      case (sel_i)
         MUL_SEL_IN0: m1_d = {1'b0, in0_i};
         MUL_SEL_IN1: m1_d = {1'b0, in1_i};
         MUL_SEL_PRE: m1_d = pre_d;
         MUL_SEL_OTH: m1_d = {1'b0, oth_in1_i};
         MUL_SEL_ONE: m1_d = {{W{1'b0}}, 1'b1};
         default:     m1_d = '0;
      endcase
   end

   // A disabled lane passes both operands through as {m0, m1}.
   always_comb begin
      a_ext  = {{(W + 1){1'b0}}, pre_q};
      b_ext  = {{(W + 1){1'b0}}, m1_q};
      prod_d = en_q ? (a_ext * b_ext) : {pre_q, m1_q};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pre_q  <= '0;
         m1_q   <= '0;
         en_q   <= 1'b0;
         prod_q <= '0;
      end else begin
         if (s1_ld_i) begin
            pre_q <= pre_d;
            m1_q  <= m1_d;
            en_q  <= en_i;
         end
         if (s2_ld_i) begin
            prod_q <= prod_d;
         end
      end
   end

   assign prod_o = prod_q;

endmodule

// File: rtl/alu_pipe.sv
// Three-stage pipelined dual-lane ALU with valid/ready back-pressure, tag passthrough and
// an accumulate mode whose running sum persists across commands.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int unsigned W     = 8,
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [W-1:0]     x0,
   input  logic [W-1:0]     x1,
   input  logic [W-1:0]     y0,
   input  logic [W-1:0]     y1,
   input  alu_ctrl_t        ctrl,
   input  logic [TAG_W-1:0] tag,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [2*W+1:0]   res_q,
   output logic             carry_q,
   output logic [TAG_W-1:0] tag_q
);

   localparam int unsigned PW = 2 * W + 2;

   logic             s1_valid_q, s2_valid_q, s3_valid_q;
   logic             s1_ready, s2_ready, s3_ready;
   logic             s1_ld, s2_ld, s3_ld;
   post_ctrl_t       s1_pc_q, s2_pc_q;
   logic [TAG_W-1:0] s1_tag_q, s2_tag_q;
   logic [PW-1:0]    xp, yp;
   logic [PW-1:0]    acc_q, base;
   logic [PW:0]      sum;

   // A stage is free when empty or when its occupant moves on this cycle.
   always_comb begin
      s3_ready  = !s3_valid_q || res_ready;
      s2_ready  = !s2_valid_q || s3_ready;
      s1_ready  = !s1_valid_q || s2_ready;
      cmd_ready = s1_ready;
      s1_ld     = s1_ready && cmd_valid;
      s2_ld     = s2_ready && s1_valid_q;
      s3_ld     = s3_ready && s2_valid_q;
      res_valid = s3_valid_q;
   end

   alu_lane #(.W(W)) u_lane_x (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .s1_ld_i   (s1_ld),
      .s2_ld_i   (s2_ld),
      .in0_i     (x0),
      .in1_i     (x1),
      .oth_in1_i (y1),
      .en_i      (ctrl.pre_x_en),
      .sub_i     (ctrl.pre_x_sub),
      .sel_i     (ctrl.mul_x_sel),
      .prod_o    (xp)
   );

   alu_lane #(.W(W)) u_lane_y (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .s1_ld_i   (s1_ld),
      .s2_ld_i   (s2_ld),
      .in0_i     (y0),
      .in1_i     (y1),
      .oth_in1_i (x1),
      .en_i      (ctrl.pre_y_en),
      .sub_i     (ctrl.pre_y_sub),
      .sel_i     (ctrl.mul_y_sel),
      .prod_o    (yp)
   );

   always_comb begin
      base = s2_pc_q.acc_clr ? '0 : acc_q;
      if (!s2_pc_q.post_en) begin
         sum = {1'b0, xp[W:0], yp[W:0]};
      end else if (s2_pc_q.acc_en) begin
         sum = s2_pc_q.post_sub ? ({1'b0, base} - {1'b0, xp}) : ({1'b0, base} + {1'b0, xp});
      end else begin
         sum = s2_pc_q.post_sub ? ({1'b0, xp} - {1'b0, yp}) : ({1'b0, xp} + {1'b0, yp});
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s3_valid_q <= 1'b0;
         s1_pc_q    <= '0;
         s2_pc_q    <= '0;
         s1_tag_q   <= '0;
         s2_tag_q   <= '0;
         acc_q      <= '0;
         res_q      <= '0;
         carry_q    <= 1'b0;
         tag_q      <= '0;
      end else begin
         if (s1_ready) s1_valid_q <= cmd_valid;
         if (s2_ready) s2_valid_q <= s1_valid_q;
         if (s3_ready) s3_valid_q <= s2_valid_q;
         if (s1_ld) begin
            s1_pc_q  <= '{post_en: ctrl.post_en, post_sub: ctrl.post_sub,
                          acc_en: ctrl.acc_en, acc_clr: ctrl.acc_clr};
            s1_tag_q <= tag;
         end
         if (s2_ld) begin
            s2_pc_q  <= s1_pc_q;
            s2_tag_q <= s1_tag_q;
         end
         if (s3_ld) begin
            res_q   <= sum[PW-1:0];
            carry_q <= sum[PW];
            tag_q   <= s2_tag_q;
            if (s2_pc_q.post_en && s2_pc_q.acc_en) acc_q <= sum[PW-1:0];
         end
      end
   end

endmodule
